// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Clears program memory to a NOP image, then receives a length-prefixed
//   byte stream and writes it into program memory from address 0. The
//   downstream core is held in reset until the load finishes.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, one extra byte after the payload is compared against
//     the running modulo-2**DATA_BITS sum of the payload bytes. A match
//     releases the core; a mismatch parks the loader in ERROR.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   rx_data     in   incoming program byte
//   rx_valid    in   rx_data valid this cycle
//   rx_ready    out  loader accepts rx_data this cycle (state only)
//   mem_we      out  program-memory write strobe
//   mem_addr    out  write address
//   mem_wdata   out  write data
//   core_reset  out  active-high reset to the exec unit
//   load_done   out  program loaded, core released
//   load_error  out  load aborted, core held in reset
//
// State table
//   CLEAR  | write NOP image over the whole memory, address 0 upward
//   HEADER | accept length byte L (0 means full memory)
//   LOAD   | write each accepted byte at the address counter
//   CHECK  | accept checksum byte and compare (checksum build only)
//   DONE   | terminal, core released
//   ERROR  | terminal, checksum mismatch, core held in reset
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 load_error
);

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Even addresses hold {NOP opcode, 4'b0}; the NOP opcode is 4'h0.
    localparam logic [3:0]           NOP_OPCODE = 4'h0;
    localparam logic [DATA_BITS-1:0] NOP_WORD   = DATA_BITS'({NOP_OPCODE, 4'b0000});
    localparam logic [ADDR_BITS-1:0] ADDR_MAX   = '1;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] len_q, len_d;
    logic                 last_byte;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_BITS-1:0] sum_q, sum_d;
`endif

    // L=0 encodes the full memory: len_q-1 wraps to ADDR_MAX, so the same
    // compare terminates after 2**ADDR_BITS bytes.
    assign last_byte = (cnt_q == (len_q - ADDR_BITS'(1)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        mem_we     = 1'b0;
        mem_addr   = cnt_q;
        mem_wdata  = rx_data;
        rx_ready   = 1'b0;
        core_reset = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = cnt_q[0] ? '0 : NOP_WORD;
                cnt_d     = cnt_q + ADDR_BITS'(1);
                if (cnt_q == ADDR_MAX) begin
                    state_d = HEADER;
                    cnt_d   = '0;
                end
            end
            HEADER: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d   = ADDR_BITS'(rx_data);
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + ADDR_BITS'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_data;
                    if (last_byte) state_d = CHECK;
`else
                    if (last_byte) state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? DONE : ERROR;
                end
            end
            ERROR: begin
                load_error = 1'b1;
            end
`endif
            DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // While reset is held the outputs show the quiescent reset values,
        // not the CLEAR-state write strobe.
        if (reset) begin
            mem_we     = 1'b0;
            rx_ready   = 1'b0;
            core_reset = 1'b1;
            load_done  = 1'b0;
            load_error = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: DATA_BITS, default 8, width of memory data and byte stream.
REQ-002 Parameter: ADDR_BITS, default 8, memory address width; memory depth is 2**ADDR_BITS bytes.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rx_data  input  DATA_BITS  incoming program byte.
REQ-006 Port: rx_valid  input  1  rx_data valid this cycle.
REQ-007 Port: rx_ready  output  1  loader accepts rx_data this cycle.
REQ-008 Port: mem_we  output  1  program-memory write strobe.
REQ-009 Port: mem_addr  output  ADDR_BITS  write address.
REQ-010 Port: mem_wdata  output  DATA_BITS  write data.
REQ-011 Port: core_reset  output  1  active-high reset to the downstream exec_unit.
REQ-012 Port: load_done  output  1  program loaded, core released.
REQ-013 Port: load_error  output  1  load aborted; core held in reset.

Function
REQ-014 An rx byte SHALL transfer only in a cycle where rx_valid and rx_ready are both 1; rx_ready SHALL depend only on state, never combinationally on rx_valid.
REQ-015 States SHALL be CLEAR, HEADER, LOAD, CHECK, DONE, ERROR.
REQ-016 CLEAR: mem_we=1 for 2**ADDR_BITS consecutive cycles, address 0 upward; even addresses written {isa_pkg::NOP, 4'b0}, odd addresses 0; rx_ready=0; then go to HEADER.
REQ-017 HEADER: rx_ready=1; accepted byte L is the load length in bytes, L=0 meaning 2**ADDR_BITS; go to LOAD with address counter 0.
REQ-018 LOAD: rx_ready=1; each accepted byte SHALL be written in the same cycle (mem_we=1, mem_addr=counter, mem_wdata=rx_data), counter increments by 1 modulo 2**ADDR_BITS.
REQ-019 LOAD with rx_valid=0 SHALL hold state, counter and mem_we=0 indefinitely (stall).
REQ-020 After the L-th byte is written, go to CHECK when CHECKSUM_EN is defined, else DONE, on the next cycle.
REQ-021 mem_we SHALL be 0 in HEADER, CHECK, DONE, ERROR, and whenever no byte is accepted in LOAD.
REQ-022 core_reset SHALL be 1 in every state except DONE; DONE is terminal, core_reset=0, load_done=1, rx_ready=0.
REQ-023 ERROR is terminal: core_reset=1, load_error=1, rx_ready=0; exit only via reset.
REQ-024 load_done and load_error SHALL never be 1 simultaneously.
REQ-025 Bytes offered while rx_ready=0 SHALL be ignored and not counted.

Reset
REQ-026 On reset=1 at a clock edge: state=CLEAR, address counter=0, checksum=0, core_reset=1, mem_we=0, rx_ready=0, load_done=0, load_error=0.
REQ-027 Reset asserted in any state, including mid-LOAD, SHALL abort the load and restart from CLEAR; partially written memory is re-cleared.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: when defined, a running DATA_BITS-wide sum modulo 2**DATA_BITS of the L payload bytes is kept; in CHECK, rx_ready=1 and one accepted byte is compared; equal -> DONE, unequal -> ERROR; header byte is excluded from the sum.
REQ-029 Without LOADER_CHECKSUM_EN: no checksum register, CHECK state unreachable, LOAD goes straight to DONE, load_error is constant 0.

Verification
REQ-030 Reset then idle rx: exactly 256 cycles of mem_we=1, addr 0..255, data 0x00/0x00 pattern per NOP encoding; then rx_ready=1, core_reset=1.
REQ-031 Stream L=4, bytes 0x10,0x01,0x11,0x10 (checksum off): memory[0..3] equal those bytes, memory[4..255] remain NOP pattern, core_reset falls one cycle after 4th byte, load_done=1.
REQ-032 Same stream with rx_valid toggling 1/0 each cycle: identical memory result, no duplicate or skipped writes.
REQ-033 With LOADER_CHECKSUM_EN: L=2, 0x20,0x05, checksum 0x25 -> load_done=1; checksum 0x26 -> load_error=1, core_reset stays 1.
REQ-034 L=0 (256 bytes, value=index): counter wraps to 0 after address 255, all 256 locations written, then DONE.
REQ-035 Assert reset after 2 of 4 payload bytes: CLEAR rewrites all 256 locations, new header accepted, load_done=0 until new load completes.
